// File: rtl/vdg_chargen_if.sv
// Character generator bus: host load handshake, glyph ROM port and pixel output.
interface vdg_chargen_if #(
  parameter int unsigned CHAR_BITS = 6,
  parameter int unsigned GLYPH_W   = 8
);
  logic                 ce_pix;
  logic                 load;
  logic [CHAR_BITS-1:0] char_code;
  logic [3:0]           row;
  logic                 inv;
  logic                 ready;
  logic [CHAR_BITS+3:0] rom_addr;
  logic [GLYPH_W-1:0]   rom_data;
  logic                 pix;
  logic                 pix_valid;
  logic                 overrun;

  // Character generator side
  modport slave (
    input  load, char_code, row, inv, rom_data,
    output ce_pix, ready, rom_addr, pix, pix_valid, overrun
  );

  // Host / ROM side
  modport master (
    output load, char_code, row, inv, rom_data,
    input  ce_pix, ready, rom_addr, pix, pix_valid, overrun
  );
endinterface

// File: rtl/vdg_chargen.sv
// Text-mode character generator: fetches one glyph row per accepted cell from an
// external ROM and serialises it MSB-first at the pixel clock-enable rate.
module vdg_chargen #(
  parameter int unsigned GLYPH_W   = 8,
  parameter int unsigned GLYPH_H   = 7,
  parameter int unsigned TOP_PAD   = 3,
  parameter int unsigned CHAR_BITS = 6,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned CE_DIV    = 4
) (
  input logic           clk,
  input logic           reset,
  vdg_chargen_if.slave  bus
);

  localparam int unsigned DivW  = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int unsigned CntW  = $clog2(GLYPH_W + 1);
  localparam int unsigned AddrW = CHAR_BITS + 4;

  // The fetch must complete before the next pixel enable for gapless streaming.
  if (CE_DIV < ROM_LAT + 2) begin : g_bad_ce_div
    $error("vdg_chargen: CE_DIV must be at least ROM_LAT+2");
  end
  if (ROM_LAT > 4) begin : g_bad_rom_lat
    $error("vdg_chargen: ROM_LAT must be in 0..4");
  end
  if (GLYPH_H < 2 || GLYPH_H > 16) begin : g_bad_glyph_h
    $error("vdg_chargen: GLYPH_H must be in 2..16");
  end

  logic [DivW-1:0]    div_q, div_d;
  logic [GLYPH_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]    rem_q, rem_d;
  logic               in_flight_q, in_flight_d;
  logic [ROM_LAT:0]   fetch_q, fetch_d;
  logic               blank_q, blank_d;
  logic               inv_q, inv_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic               pix_q, pix_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               ce;
  logic               ready;
  logic               accept;
  logic               fetch_done;
  logic               blank_now;
  logic [3:0]         glyph_row;
  logic [31:0]        row_ext;

  assign ce         = (div_q == DivW'(CE_DIV - 1));
  assign ready      = !in_flight_q && (rem_q <= CntW'(1));
  assign accept     = bus.load && ce && ready;
  assign fetch_done = fetch_q[ROM_LAT];
  assign glyph_row  = bus.row - 4'(TOP_PAD);
  assign row_ext    = 32'(bus.row);
  assign blank_now  = (row_ext < TOP_PAD) || (row_ext >= TOP_PAD + GLYPH_H);

  assign bus.ce_pix    = ce;
  assign bus.ready     = ready;
  assign bus.rom_addr  = addr_q;
  assign bus.pix       = pix_q;
  assign bus.pix_valid = valid_q;
  assign bus.overrun   = overrun_q;

  // Next state: divider, fetch pipeline, shifter and sticky overrun
  always_comb begin
    div_d       = ce ? '0 : div_q + DivW'(1);
    shift_d     = shift_q;
    rem_d       = rem_q;
    in_flight_d = in_flight_q;
    blank_d     = blank_q;
    inv_d       = inv_q;
    addr_d      = addr_q;
    pix_d       = pix_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q | (bus.load & ce & ~ready);

    // One-hot marker travels ROM_LAT+1 stages: address register plus ROM latency
    fetch_d[0] = accept;
    for (int unsigned i = 1; i <= ROM_LAT; i++) begin
      fetch_d[i] = fetch_q[i-1];
    end

    if (accept) begin
      in_flight_d = 1'b1;
      blank_d     = blank_now;
      inv_d       = bus.inv;
      if (!blank_now) begin
        addr_d = {bus.char_code, glyph_row};
      end
    end

    if (ce) begin
      if (rem_q != '0) begin
        pix_d   = shift_q[GLYPH_W-1];
        valid_d = 1'b1;
      end else begin
        pix_d   = 1'b0;
        valid_d = 1'b0;
      end
    end

    // A fetch never lands on a ce cycle, so the load and the shift are exclusive
    if (fetch_done) begin
      shift_d     = (blank_q ? '0 : bus.rom_data) ^ {GLYPH_W{inv_q}};
      rem_d       = CntW'(GLYPH_W);
      in_flight_d = 1'b0;
    end else if (ce && rem_q != '0) begin
      shift_d = shift_q << 1;
      rem_d   = rem_q - CntW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      in_flight_q <= 1'b0;
      fetch_q     <= '0;
      blank_q     <= 1'b0;
      inv_q       <= 1'b0;
      addr_q      <= '0;
      pix_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      in_flight_q <= in_flight_d;
      fetch_q     <= fetch_d;
      blank_q     <= blank_d;
      inv_q       <= inv_d;
      addr_q      <= addr_d;
      pix_q       <= pix_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_vdg_chargen.sv
// Bench for vdg_chargen: pixel-queue reference model checked every cycle, plus
// literal glyph sequences for the directed cases and a randomized phase.
module tb_vdg_chargen;
  localparam int unsigned GLYPH_W   = 8;
  localparam int unsigned GLYPH_H   = 7;
  localparam int unsigned TOP_PAD   = 3;
  localparam int unsigned CHAR_BITS = 6;
  localparam int unsigned ROM_LAT   = 1;
  localparam int unsigned CE_DIV    = 4;
  localparam int unsigned AW        = CHAR_BITS + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vdg_chargen_if #(.CHAR_BITS(CHAR_BITS), .GLYPH_W(GLYPH_W)) bus ();

  vdg_chargen #(
    .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .TOP_PAD(TOP_PAD),
    .CHAR_BITS(CHAR_BITS), .ROM_LAT(ROM_LAT), .CE_DIV(CE_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [GLYPH_W-1:0] rom_fn(input logic [AW-1:0] a);
    case (a)
      10'h050: rom_fn = 8'hA5;
      10'h010: rom_fn = 8'hFF;
      10'h020: rom_fn = 8'h81;
      default: rom_fn = a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h3C;
    endcase
  endfunction

  // Glyph ROM with one cycle of read latency
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pixels still owed; one pops per ce.
  int              m_div = 0;
  bit              m_q[$];
  logic            m_pix = 1'b0;
  logic            m_valid = 1'b0;
  logic            m_ovr = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  bit              checking = 1'b0;
  bit              prev_ce = 1'b0;
  bit              chk_ready_next = 1'b0;
  logic [1:0]      cap[$];

  always @(negedge clk) begin
    bit ce;
    bit rdy;
    bit blank;
    logic [3:0] gr;
    logic [GLYPH_W-1:0] g;
    ce = (m_div == int'(CE_DIV) - 1);
    if (checking) begin
      chk("ce_pix", {31'b0, bus.ce_pix}, {31'b0, ce});
      chk("pix", {31'b0, bus.pix}, {31'b0, m_pix});
      chk("pix_valid", {31'b0, bus.pix_valid}, {31'b0, m_valid});
      chk("overrun", {31'b0, bus.overrun}, {31'b0, m_ovr});
      chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
      if (ce || chk_ready_next)
        chk("ready", {31'b0, bus.ready}, {31'b0, (m_q.size() <= 1)});
      if (prev_ce) cap.push_back({bus.pix_valid, bus.pix});
      prev_ce = ce;
    end
    chk_ready_next = 1'b0;
    if (reset) begin
      m_div = 0;
      m_q.delete();
      m_pix = 1'b0;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_addr = '0;
      prev_ce = 1'b0;
      chk_ready_next = 1'b1;
    end else begin
      rdy = (m_q.size() <= 1);
      m_div = ce ? 0 : m_div + 1;
      if (ce) begin
        if (m_q.size() > 0) begin
          m_pix = m_q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_pix = 1'b0;
          m_valid = 1'b0;
        end
        if (bus.load) begin
          if (rdy) begin
            gr = bus.row - 4'(TOP_PAD);
            blank = (int'(bus.row) < int'(TOP_PAD)) || (int'(bus.row) >= int'(TOP_PAD + GLYPH_H));
            if (!blank) m_addr = {bus.char_code, gr};
            g = blank ? '0 : rom_fn({bus.char_code, gr});
            if (bus.inv) g = ~g;
            for (int i = GLYPH_W - 1; i >= 0; i--) m_q.push_back(g[i]);
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  end

  // Waits for the (skip+1)-th ce cycle and presents a load during it
  task automatic drive_load(input logic [CHAR_BITS-1:0] code, input logic [3:0] r,
                            input logic iv, input int skip);
    int seen = 0;
    bit got = 1'b0;
    for (int i = 0; i < (skip + 2) * int'(CE_DIV) && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ce_pix) begin
        if (seen == skip) got = 1'b1;
        else seen++;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL ce_timeout: got no ce_pix want ce_pix within %0d cycles", (skip + 2) * CE_DIV);
      return;
    end
    bus.load = 1'b1;
    bus.char_code = code;
    bus.row = r;
    bus.inv = iv;
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic step_and_clear();
    @(posedge clk); #1;
    cap.delete();
  endtask

  task automatic check_cap(input string name, input logic [15:0] exp, input int n);
    logic [15:0] got_p = '0;
    logic [15:0] got_v = '0;
    logic [15:0] mask;
    logic        trail;
    mask = 16'((32'd1 << n) - 1);
    for (int i = 0; i < n; i++) begin
      if (i < cap.size()) begin
        got_p[n-1-i] = cap[i][0];
        got_v[n-1-i] = cap[i][1];
      end
    end
    trail = (cap.size() > n) ? cap[n][1] : 1'b1;
    chk({name, "_pix"}, 32'(got_p), 32'(exp));
    chk({name, "_valid"}, 32'(got_v), 32'(mask));
    chk({name, "_end"}, {31'b0, trail}, 32'd0);
  endtask

  initial begin
    int vcount;
    bus.load = 1'b0;
    bus.char_code = '0;
    bus.row = '0;
    bus.inv = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("ready_initial", {31'b0, bus.ready}, 32'd1);

    // Plain glyph row, then inverse video
    drive_load(6'd5, 4'd3, 1'b0, 0);
    chk("rom_addr_050", 32'(bus.rom_addr), 32'h050);
    step_and_clear();
    repeat (11 * CE_DIV) @(posedge clk);
    check_cap("a5", 16'h00A5, 8);

    drive_load(6'd5, 4'd3, 1'b1, 0);
    step_and_clear();
    repeat (11 * CE_DIV) @(posedge clk);
    check_cap("a5_inv", 16'h005A, 8);

    // Blank rows: top pad and bottom pad
    drive_load(6'd5, 4'd1, 1'b0, 0);
    step_and_clear();
    repeat (11 * CE_DIV) @(posedge clk);
    check_cap("pad_top", 16'h0000, 8);
    chk("rom_addr_hold", 32'(bus.rom_addr), 32'h050);

    drive_load(6'd5, 4'd10, 1'b1, 0);
    step_and_clear();
    repeat (11 * CE_DIV) @(posedge clk);
    check_cap("pad_bot_inv", 16'h00FF, 8);

    // Back-to-back cells, second load on the last-pixel ce
    drive_load(6'd1, 4'd3, 1'b0, 0);
    step_and_clear();
    drive_load(6'd2, 4'd3, 1'b0, 7);
    repeat (11 * CE_DIV) @(posedge clk);
    check_cap("gapless", 16'hFF81, 16);

    // Load with 4 pixels left is rejected
    drive_load(6'd5, 4'd3, 1'b0, 0);
    step_and_clear();
    drive_load(6'd9, 4'd5, 1'b1, 3);
    chk("overrun_set", {31'b0, bus.overrun}, 32'd1);
    repeat (11 * CE_DIV) @(posedge clk);
    check_cap("ovr_cell", 16'h00A5, 8);
    chk("overrun_sticky", {31'b0, bus.overrun}, 32'd1);

    // Reset two clocks after acceptance discards the cell
    drive_load(6'd5, 4'd3, 1'b0, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("ready_after_reset", {31'b0, bus.ready}, 32'd1);
    chk("overrun_cleared", {31'b0, bus.overrun}, 32'd0);
    vcount = 0;
    repeat (12 * CE_DIV) begin
      @(posedge clk); #1;
      if (bus.pix_valid) vcount++;
    end
    chk("no_pix_after_reset", 32'(vcount), 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      bus.char_code = CHAR_BITS'($urandom);
      bus.row = 4'($urandom);
      bus.inv = 1'($urandom);
      bus.load = bus.ce_pix ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    bus.load = 1'b0;
    reset = 1'b0;
    repeat (12 * CE_DIV) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
